// File: rtl/xfer_pkg.sv
// Shared types and constants for the register-file <-> RAM transfer sequencer.
// Holds the FSM state encoding and the data/register widths used by every file.
// No logic lives here.
package xfer_pkg;

    localparam int DATA_W          = 16;
    localparam int REG_AW          = 3;
    localparam int ADDR_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_mem_xfer_if.sv
// Bundle of the command, RAM and register-file buses of the transfer sequencer.
// master = sequencer side, slave = control unit / RAM / register file side.
// Pure wiring: no latency, no state.
interface regfile_mem_xfer_if #(
    parameter int ADDR_W = xfer_pkg::ADDR_W_DEF
);
    import xfer_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_store;
    logic [REG_AW-1:0]   cmd_reg;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                done;
    logic                err;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    logic [REG_AW-1:0]   rf_read_addr;
    logic [DATA_W-1:0]   rf_read_data;
    logic [REG_AW-1:0]   rf_write_addr;
    logic                rf_write_enable;
    logic [DATA_W-1:0]   rf_write_data;

    modport master (
        input  cmd_valid, cmd_store, cmd_reg, cmd_addr,
        output cmd_ready, done, err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output rf_read_addr,
        input  rf_read_data,
        output rf_write_addr, rf_write_enable, rf_write_data
    );

    modport slave (
        output cmd_valid, cmd_store, cmd_reg, cmd_addr,
        input  cmd_ready, done, err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  rf_read_addr,
        output rf_read_data,
        input  rf_write_addr, rf_write_enable, rf_write_data
    );

endinterface

// File: rtl/xfer_timeout_ctr.sv
// Counts REQ cycles without mem_ack; expire marks the edge that reaches TIMEOUT_CYC.
// Latency: expire is combinational during the TIMEOUT_CYC-th un-acked REQ cycle.
// Backpressure: none; only used when XFER_TIMEOUT_EN is defined.
module xfer_timeout_ctr
    import xfer_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 4) ? 4 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the number of un-acked REQ cycles already completed.
    assign expire = inc && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/regfile_mem_xfer.sv
// Load/store sequencer between the 8x16 register file and data RAM (timeout via XFER_TIMEOUT_EN).
// Latency: store done 1 cycle after ack edge; load writes rf 1 cycle after ack edge, done 1 later.
// Backpressure: cmd_ready only in IDLE; mem_req held until mem_ack.
module regfile_mem_xfer
    import xfer_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    regfile_mem_xfer_if.master bus
);

    state_t              state;
    state_t              state_nxt;

    logic                st_store;
    logic [REG_AW-1:0]   st_reg;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                accept;
    logic                expire;
    logic                cmd_ready;
    logic                mem_req;
    logic                mem_we;
    logic                rf_write_enable;
    logic                done;

    assign accept = (state == IDLE) && bus.cmd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        rf_write_enable = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                mem_we  = st_store;
                if (bus.mem_ack) begin
                    state_nxt = st_store ? DONE : WB;
                end else if (expire) begin
                    state_nxt = IDLE;
                end
            end
            WB: begin
                rf_write_enable = 1'b1;
                state_nxt       = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Store data is sampled from the combinational rf read port on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_store <= 1'b0;
            st_reg   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                st_store <= bus.cmd_store;
                st_reg   <= bus.cmd_reg;
                addr_q   <= bus.cmd_addr;
                if (bus.cmd_store) begin
                    wdata_q <= bus.rf_read_data;
                end
            end
            if ((state == REQ) && bus.mem_ack && !st_store) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

`ifdef XFER_TIMEOUT_EN
    logic err_q;

    xfer_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .inc    ((state == REQ) && !bus.mem_ack),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
        end
    end

    assign bus.err = err_q;
`else
    assign expire  = 1'b0;
    assign bus.err = 1'b0;

    if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_unused
    end
`endif

    assign bus.cmd_ready       = cmd_ready;
    assign bus.done            = done;
    assign bus.mem_req         = mem_req;
    assign bus.mem_we          = mem_we;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.rf_read_addr    = (state == IDLE) ? bus.cmd_reg : st_reg;
    assign bus.rf_write_enable = rf_write_enable;
    assign bus.rf_write_addr   = rf_write_enable ? st_reg  : '0;
    assign bus.rf_write_data   = rf_write_enable ? rdata_q : '0;

endmodule

// File: tb/tb_regfile_mem_xfer.sv
// Directed bench for regfile_mem_xfer with a register-file model and scoreboard queues.
// Expected rf writes / RAM transactions are queued when commands are driven.
module tb_regfile_mem_xfer;
    import xfer_pkg::*;

    `define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp); end end

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic        we;
        logic [7:0]  a;
        logic [15:0] d;
    } mem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wr_seen = 0;
    int   done_seen = 0;
    int   err_seen = 0;
    int   exp_wr_total = 0;
    int   exp_done_total = 0;
    int   exp_err_total = 0;

    wr_t  exp_wr[$];
    mem_t exp_mem[$];
    logic [15:0] rf [8];

    always #5 clk = ~clk;

    regfile_mem_xfer_if #(.ADDR_W(8)) bus ();

    regfile_mem_xfer #(.ADDR_W(8), .TIMEOUT_CYC(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rf_read_data = rf[bus.rf_read_addr];

    // Monitor: register-file write model plus scoreboard pops at the falling edge.
    always @(negedge clk) begin
        wr_t  w;
        mem_t m;
        if (bus.rf_write_enable) begin
            `CHK("rf_wr_expected", (exp_wr.size() > 0), 1'b1)
            if (exp_wr.size() > 0) begin
                w = exp_wr.pop_front();
                `CHK("rf_wr_addr", bus.rf_write_addr, w.a)
                `CHK("rf_wr_data", bus.rf_write_data, w.d)
            end
            rf[bus.rf_write_addr] = bus.rf_write_data;
            wr_seen++;
        end
        if (bus.mem_req && bus.mem_ack) begin
            `CHK("mem_txn_expected", (exp_mem.size() > 0), 1'b1)
            if (exp_mem.size() > 0) begin
                m = exp_mem.pop_front();
                `CHK("mem_we", bus.mem_we, m.we)
                `CHK("mem_addr", bus.mem_addr, m.a)
                if (m.we) `CHK("mem_wdata", bus.mem_wdata, m.d)
            end
        end
        if (bus.done) done_seen++;
        if (bus.err) err_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
        rf[2] = 16'h1234;
        bus.cmd_valid = 1'b0;
        bus.cmd_store = 1'b0;
        bus.cmd_reg   = 3'd0;
        bus.cmd_addr  = 8'h00;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;

        // Reset state
        tick();
        `CHK("rst_cmd_ready", bus.cmd_ready, 1'b1)
        `CHK("rst_mem_req", bus.mem_req, 1'b0)
        `CHK("rst_rf_we", bus.rf_write_enable, 1'b0)
        `CHK("rst_done", bus.done, 1'b0)
        `CHK("rst_err", bus.err, 1'b0)
        rst = 1'b0;
        tick();

        // Load r5 <- RAM[0x3C] = 0xBEEF, ack sampled two edges after accept
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_reg = 3'd5; bus.cmd_addr = 8'h3C;
        exp_wr.push_back('{a: 3'd5, d: 16'hBEEF});
        exp_mem.push_back('{we: 1'b0, a: 8'h3C, d: 16'h0000});
        exp_wr_total++; exp_done_total++;
        #1;
        `CHK("ld_idle_rd_addr", bus.rf_read_addr, 3'd5)
        tick();
        bus.cmd_valid = 1'b0;
        `CHK("ld_req", bus.mem_req, 1'b1)
        `CHK("ld_we", bus.mem_we, 1'b0)
        `CHK("ld_addr", bus.mem_addr, 8'h3C)
        `CHK("ld_busy", bus.cmd_ready, 1'b0)
        tick();
        `CHK("ld_req_held", bus.mem_req, 1'b1)
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000;
        `CHK("ld_wb_we", bus.rf_write_enable, 1'b1)
        `CHK("ld_wb_addr", bus.rf_write_addr, 3'd5)
        `CHK("ld_wb_data", bus.rf_write_data, 16'hBEEF)
        `CHK("ld_wb_req_low", bus.mem_req, 1'b0)
        `CHK("ld_wb_no_done", bus.done, 1'b0)
        tick();
        `CHK("ld_done", bus.done, 1'b1)
        `CHK("ld_done_rf_we", bus.rf_write_enable, 1'b0)
        tick();
        `CHK("ld_idle_done", bus.done, 1'b0)
        `CHK("ld_idle_ready", bus.cmd_ready, 1'b1)
        `CHK("ld_rf5", rf[5], 16'hBEEF)

        // Store r2 (0x1234) -> RAM[0x10], immediate ack
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b1; bus.cmd_reg = 3'd2; bus.cmd_addr = 8'h10;
        exp_mem.push_back('{we: 1'b1, a: 8'h10, d: 16'h1234});
        exp_done_total++;
        tick();
        bus.cmd_valid = 1'b0;
        bus.mem_ack = 1'b1;
        `CHK("st_req", bus.mem_req, 1'b1)
        `CHK("st_we", bus.mem_we, 1'b1)
        `CHK("st_addr", bus.mem_addr, 8'h10)
        `CHK("st_wdata", bus.mem_wdata, 16'h1234)
        tick();
        bus.mem_ack = 1'b0;
        `CHK("st_done", bus.done, 1'b1)
        `CHK("st_req_1cyc", bus.mem_req, 1'b0)
        tick();
        `CHK("st_idle_done", bus.done, 1'b0)

        // Back-to-back: load r3 <- 0x0007, then store r3 -> 0x20 with cmd_valid held
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_reg = 3'd3; bus.cmd_addr = 8'h05;
        exp_wr.push_back('{a: 3'd3, d: 16'h0007});
        exp_mem.push_back('{we: 1'b0, a: 8'h05, d: 16'h0000});
        exp_mem.push_back('{we: 1'b1, a: 8'h20, d: 16'h0007});
        exp_wr_total++; exp_done_total += 2;
        tick();
        bus.cmd_store = 1'b1; bus.cmd_reg = 3'd3; bus.cmd_addr = 8'h20;
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0007;
        tick();
        bus.mem_ack = 1'b0;
        `CHK("b2b_wb", bus.rf_write_enable, 1'b1)
        tick();
        `CHK("b2b_done1", bus.done, 1'b1)
        `CHK("b2b_not_ready", bus.cmd_ready, 1'b0)
        tick();
        `CHK("b2b_ready", bus.cmd_ready, 1'b1)
        `CHK("b2b_rd_data", bus.rf_read_data, 16'h0007)
        tick();
        bus.cmd_valid = 1'b0;
        `CHK("b2b_st_req", bus.mem_req, 1'b1)
        `CHK("b2b_st_we", bus.mem_we, 1'b1)
        `CHK("b2b_st_addr", bus.mem_addr, 8'h20)
        `CHK("b2b_st_wdata", bus.mem_wdata, 16'h0007)
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        `CHK("b2b_done2", bus.done, 1'b1)
        tick();

        // Stray ack while idle
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hAAAA;
        tick();
        bus.mem_ack = 1'b0;
        `CHK("stray_ready", bus.cmd_ready, 1'b1)
        `CHK("stray_req", bus.mem_req, 1'b0)
        `CHK("stray_done", bus.done, 1'b0)
        tick();
        `CHK("stray_ready2", bus.cmd_ready, 1'b1)

        // Reset during a load wait
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_reg = 3'd6; bus.cmd_addr = 8'h40;
        tick();
        bus.cmd_valid = 1'b0;
        `CHK("rstreq_req", bus.mem_req, 1'b1)
        rst = 1'b1;
        #1;
        `CHK("rstreq_req_low", bus.mem_req, 1'b0)
        `CHK("rstreq_rf_we", bus.rf_write_enable, 1'b0)
        `CHK("rstreq_done", bus.done, 1'b0)
        tick();
        rst = 1'b0;
        #1;
        `CHK("rstreq_ready", bus.cmd_ready, 1'b1)
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        tick();
        `CHK("rstreq_rf6", rf[6], 16'h1006)

`ifdef XFER_TIMEOUT_EN
        // Load never acked: err 15 cycles after req rises
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_reg = 3'd4; bus.cmd_addr = 8'h77;
        exp_err_total++;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        `CHK("tmo_req_c15", bus.mem_req, 1'b1)
        `CHK("tmo_err_c15", bus.err, 1'b0)
        tick();
        `CHK("tmo_err", bus.err, 1'b1)
        `CHK("tmo_req_drop", bus.mem_req, 1'b0)
        `CHK("tmo_ready", bus.cmd_ready, 1'b1)
        tick();
        `CHK("tmo_err_1cyc", bus.err, 1'b0)
        `CHK("tmo_ready2", bus.cmd_ready, 1'b1)
        `CHK("tmo_rf4", rf[4], 16'h1004)

        // Ack on cycle 15 wins over expiry
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_reg = 3'd7; bus.cmd_addr = 8'h78;
        exp_wr.push_back('{a: 3'd7, d: 16'h5A5A});
        exp_mem.push_back('{we: 1'b0, a: 8'h78, d: 16'h0000});
        exp_wr_total++; exp_done_total++;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A;
        tick();
        bus.mem_ack = 1'b0;
        `CHK("tmo_ack_err", bus.err, 1'b0)
        `CHK("tmo_ack_wb", bus.rf_write_enable, 1'b1)
        tick();
        `CHK("tmo_ack_done", bus.done, 1'b1)
        tick();
`endif

        // Totals against the scoreboard
        `CHK("wr_count", wr_seen, exp_wr_total)
        `CHK("done_count", done_seen, exp_done_total)
        `CHK("err_count", err_seen, exp_err_total)
        `CHK("wr_queue_empty", exp_wr.size(), 0)
        `CHK("mem_queue_empty", exp_mem.size(), 0)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
